motor_cycle_sequencer: RTL and testbench
========================================

Name: motor_cycle_sequencer

Overview:
Sequences the washer DC motor through repeated agitation cycles: forward run, pause, reverse run, pause, for a programmed number of cycles. An internal prescaler divides i_clk into a phase-timing tick. Outputs drive the motor direction enables and the speed code to the motor PWM stage, and report status to the AXI register file.

Parameters:
TICK_DIV, 100_000_000, i_clk cycles per timing tick (1 s at 100 MHz); legal range >= 2.
T_W, 8, width of the run time, pause time and remaining-tick fields.
C_W, 8, width of the cycle-count fields.

Ports:
i_clk  input  1  system clock; all logic on rising edge.
i_reset  input  1  synchronous reset, active-low (0 = reset).
i_start  input  1  start request; sampled only in IDLE.
i_stop  input  1  abort request; highest priority after reset.
i_run_time  input  T_W  ticks per FWD and per REV phase.
i_pause_time  input  T_W  ticks per pause phase.
i_cycles  input  C_W  number of FWD/PAUSE/REV/PAUSE cycles.
i_speed  input  2  speed code passed to the PWM stage.
o_fwd  output  1  forward enable.
o_rev  output  1  reverse enable.
o_speed  output  2  latched speed code; 0 when not running.
o_busy  output  1  high in any state except IDLE.
o_done  output  1  one-cycle pulse on normal completion.
o_remain  output  T_W  ticks left in the current phase.
o_cycle  output  C_W  number of completed cycles.

Behaviour:
- Reset (i_reset=0 at a clock edge):
  - State goes to IDLE.
  - All outputs, prescaler, and latched configuration are cleared to 0.
  - Reset overrides every other input, including mid-run.
- States: IDLE, FWD, PAUSE1, REV, PAUSE2, DONE. All outputs are registered.
- IDLE, start:
  - i_start=1 latches i_run_time, i_pause_time, i_cycles and i_speed.
  - Next state is FWD, or DONE if the latched cycles or run time is 0.
- Prescaler:
  - Cleared on every phase entry.
  - Counts 0..TICK_DIV-1; a tick occurs at TICK_DIV-1.
- Phase timing:
  - o_remain loads the phase length on entry and decrements on each tick.
  - When a tick occurs with o_remain=1, the phase exits.
  - FWD/REV last exactly run_time*TICK_DIV cycles; PAUSE lasts pause_time*TICK_DIV cycles.
  - A pause_time of 0 gives a pause of exactly 1 cycle (dead time) with o_remain=0.
- Transitions:
  - FWD -> PAUSE1 -> REV -> PAUSE2.
  - On PAUSE2 exit, o_cycle increments. If the new value equals the latched cycles, go to DONE; otherwise go to FWD.
- DONE: lasts 1 cycle with o_done=1, then IDLE. o_cycle holds its value until the next start, which clears it.
- Output rules:
  - o_fwd=1 only in FWD; o_rev=1 only in REV. Both are never 1 in the same cycle.
  - o_speed equals the latched speed in FWD/REV, otherwise 0.
  - o_busy=1 in FWD, PAUSE1, REV, PAUSE2, DONE.
  - o_remain is 0 in IDLE and DONE.
- i_stop in any non-IDLE state:
  - Next cycle: IDLE, with o_fwd, o_rev, o_speed, o_remain all 0.
  - o_done is not pulsed; o_cycle holds its value.
  - i_stop beats a simultaneous tick or phase exit. i_stop in IDLE is a no-op.
- i_start and i_stop high together in IDLE: stop wins and the block stays IDLE.
- i_start while busy is ignored. Config input changes while busy have no effect.

Test Plan:
- Reset: hold i_reset=0 for 3 cycles with i_start=1 -> all outputs 0, state IDLE; after release, i_start=0 -> still idle.
- Normal run (TICK_DIV=4, run=2, pause=1, cycles=2, speed=3), start pulse at cycle 0:
  - o_fwd=1 cycles 1-8; pause 9-12; o_rev=1 cycles 13-20; pause 21-24.
  - o_cycle=1 from 25; second cycle 25-48; o_done=1 only at cycle 49; o_busy=0 at 50; o_cycle=2.
  - o_speed=3 only while o_fwd or o_rev is high.
- Zero pause (TICK_DIV=4, run=1, pause=0, cycles=1) -> FWD 4 cycles, 1-cycle PAUSE1 with both enables 0, REV 4 cycles, 1-cycle PAUSE2, DONE; no cycle with o_fwd and o_rev both 1.
- Abort mid-REV (normal-run config, i_stop at cycle 16) -> at cycle 17 IDLE, o_rev=0, o_remain=0, o_busy=0, o_cycle=0; o_done never asserts.
- Degenerate config: cycles=0, start at cycle 0 -> o_done=1 at cycle 1, o_fwd/o_rev never asserted; repeat with run=0 -> same result.
- Interference:
  - i_start re-pulsed and i_run_time changed at cycle 5 of a run -> timing unchanged.
  - i_reset=0 at cycle 10 -> all outputs 0 at cycle 11.
  - Fresh start afterwards -> full sequence with o_cycle starting at 0.

Source files
------------

// File: rtl/motor_cycle_sequencer.sv
// Washer motor agitation sequencer: FWD / PAUSE / REV / PAUSE repeated for a programmed cycle count.
// Phase lengths are counted in prescaled ticks; all outputs are registered.
module motor_cycle_sequencer #(
    parameter int TICK_DIV = 100_000_000,
    parameter int T_W      = 8,
    parameter int C_W      = 8
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic           i_stop,
    input  logic [T_W-1:0] i_run_time,
    input  logic [T_W-1:0] i_pause_time,
    input  logic [C_W-1:0] i_cycles,
    input  logic [1:0]     i_speed,
    output logic           o_fwd,
    output logic           o_rev,
    output logic [1:0]     o_speed,
    output logic           o_busy,
    output logic           o_done,
    output logic [T_W-1:0] o_remain,
    output logic [C_W-1:0] o_cycle
);

    localparam int P_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [P_W-1:0] PRE_MAX = P_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {IDLE, FWD, PAUSE1, REV, PAUSE2, DONE} state_t;

    state_t         state, state_n;
    logic [P_W-1:0] pre, pre_n;
    logic [T_W-1:0] remain_n;
    logic [T_W-1:0] run_q, pause_q;
    logic [C_W-1:0] cycles_q, cyc_n, cyc_inc;
    logic [1:0]     speed_q, speed_n;
    logic           tick, phase_end, load;

    assign tick      = (pre == PRE_MAX);
    // A zero-length pause still occupies one cycle of dead time between directions.
    assign phase_end = (o_remain == '0) || (tick && (o_remain == T_W'(1)));
    assign cyc_inc   = o_cycle + C_W'(1);

    always_comb begin
        state_n  = state;
        pre_n    = tick ? '0 : pre + P_W'(1);
        remain_n = (tick && (o_remain != '0)) ? o_remain - T_W'(1) : o_remain;
        cyc_n    = o_cycle;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                pre_n    = '0;
                remain_n = '0;
                if (i_start && !i_stop) begin
                    load  = 1'b1;
                    cyc_n = '0;
                    if ((i_cycles == '0) || (i_run_time == '0)) begin
                        state_n = DONE;
                    end else begin
                        state_n  = FWD;
                        remain_n = i_run_time;
                    end
                end
            end
            FWD: if (phase_end) begin
                state_n  = PAUSE1;
                pre_n    = '0;
                remain_n = pause_q;
            end
            PAUSE1: if (phase_end) begin
                state_n  = REV;
                pre_n    = '0;
                remain_n = run_q;
            end
            REV: if (phase_end) begin
                state_n  = PAUSE2;
                pre_n    = '0;
                remain_n = pause_q;
            end
            PAUSE2: if (phase_end) begin
                cyc_n = cyc_inc;
                pre_n = '0;
                if (cyc_inc == cycles_q) begin
                    state_n  = DONE;
                    remain_n = '0;
                end else begin
                    state_n  = FWD;
                    remain_n = run_q;
                end
            end
            DONE: begin
                state_n  = IDLE;
                pre_n    = '0;
                remain_n = '0;
            end
            default: begin
                state_n  = IDLE;
                pre_n    = '0;
                remain_n = '0;
            end
        endcase
        // Abort outranks any tick or phase exit in the same cycle.
        if (i_stop && (state != IDLE)) begin
            state_n  = IDLE;
            pre_n    = '0;
            remain_n = '0;
            cyc_n    = o_cycle;
        end
        speed_n = load ? i_speed : speed_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state    <= IDLE;
            pre      <= '0;
            run_q    <= '0;
            pause_q  <= '0;
            cycles_q <= '0;
            speed_q  <= '0;
            o_fwd    <= 1'b0;
            o_rev    <= 1'b0;
            o_speed  <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_remain <= '0;
            o_cycle  <= '0;
        end else begin
            state    <= state_n;
            pre      <= pre_n;
            if (load) begin
                run_q    <= i_run_time;
                pause_q  <= i_pause_time;
                cycles_q <= i_cycles;
            end
            speed_q  <= speed_n;
            o_fwd    <= (state_n == FWD);
            o_rev    <= (state_n == REV);
            o_speed  <= ((state_n == FWD) || (state_n == REV)) ? speed_n : 2'd0;
            o_busy   <= (state_n != IDLE);
            o_done   <= (state_n == DONE);
            o_remain <= remain_n;
            o_cycle  <= cyc_n;
        end
    end

endmodule

// File: tb/tb_motor_cycle_sequencer.sv
// Bench for motor_cycle_sequencer: driver pushes the expected output word for every cycle into a queue,
// an independent monitor pops and compares it on the falling edge.
module tb_motor_cycle_sequencer;

    localparam int TD = 4;

    typedef struct packed {
        logic       fwd;
        logic       rev;
        logic [1:0] speed;
        logic       busy;
        logic       done;
        logic [7:0] remain;
        logic [7:0] cycle;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] run_time = '0;
    logic [7:0] pause_time = '0;
    logic [7:0] cycles = '0;
    logic [1:0] speed = '0;
    logic       fwd, rev, busy, done;
    logic [1:0] speed_out;
    logic [7:0] remain, cycle;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc_no = 0;
    bit   drv_done = 1'b0;
    logic [7:0] prev_cycle = '0;

    motor_cycle_sequencer #(.TICK_DIV(TD), .T_W(8), .C_W(8)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_stop(stop),
        .i_run_time(run_time), .i_pause_time(pause_time), .i_cycles(cycles), .i_speed(speed),
        .o_fwd(fwd), .o_rev(rev), .o_speed(speed_out), .o_busy(busy), .o_done(done),
        .o_remain(remain), .o_cycle(cycle)
    );

    always #5 clk = ~clk;

    function automatic exp_t idle_vec(input logic [7:0] c);
        exp_t e = '0;
        e.cycle = c;
        return e;
    endfunction

    // Closed-form timeline: cycle t after the start edge, phases laid end to end.
    function automatic exp_t timeline(input int t, input int r, input int p, input int n, input int s);
        exp_t e = '0;
        int rl, pl, l, u, k, o;
        if (n == 0 || r == 0) begin
            if (t == 1) begin e.busy = 1; e.done = 1; end
            return e;
        end
        rl = r * TD;
        pl = (p == 0) ? 1 : p * TD;
        l  = 2 * rl + 2 * pl;
        u  = t - 1;
        k  = u / l;
        o  = u % l;
        if (k >= n) begin
            e.cycle = 8'(n);
            if (u == n * l) begin e.busy = 1; e.done = 1; end
            return e;
        end
        e.cycle = 8'(k);
        e.busy  = 1;
        if (o < rl) begin
            e.fwd = 1; e.speed = 2'(s); e.remain = 8'(r - o / TD);
        end else if (o < rl + pl) begin
            e.remain = (p == 0) ? 8'd0 : 8'(p - (o - rl) / TD);
        end else if (o < 2 * rl + pl) begin
            e.rev = 1; e.speed = 2'(s); e.remain = 8'(r - (o - rl - pl) / TD);
        end else begin
            e.remain = (p == 0) ? 8'd0 : 8'(p - (o - 2 * rl - pl) / TD);
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_case(input int r, input int p, input int n, input int s, input int total,
                            input int stop_at, input int reset_at, input int poke_at);
        exp_t e;
        exp_t held;
        held = '0;
        for (int t = 0; t <= total; t++) begin
            start = (t == 0) || (t == poke_at);
            stop  = (t == stop_at);
            rst_n = (t != reset_at);
            if (t == 0) begin
                run_time = 8'(r); pause_time = 8'(p); cycles = 8'(n); speed = 2'(s);
            end
            if (t == poke_at) run_time = 8'(r + 5);
            if (t == 0)                              e = idle_vec(prev_cycle);
            else if (reset_at >= 0 && t > reset_at)  e = '0;
            else if (stop_at >= 0 && t > stop_at)    e = idle_vec(held.cycle);
            else                                     e = timeline(t, r, p, n, s);
            if (t == stop_at) held = timeline(t, r, p, n, s);
            exp_q.push_back(e);
            if (t < total) step();
        end
        prev_cycle = e.cycle;
        start = 0; stop = 0; rst_n = 1;
        step();
    endtask

    always @(negedge clk) begin
        exp_t e, got;
        cyc_no++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {fwd, rev, speed_out, busy, done, remain, cycle};
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL out_word clk=%0d got fwd=%b rev=%b spd=%0d busy=%b done=%b rem=%0d cyc=%0d exp fwd=%b rev=%b spd=%0d busy=%b done=%b rem=%0d cyc=%0d",
                         cyc_no, got.fwd, got.rev, got.speed, got.busy, got.done, got.remain, got.cycle,
                         e.fwd, e.rev, e.speed, e.busy, e.done, e.remain, e.cycle);
            end
        end
    end

    initial begin
        // Reset held three cycles while start is requested.
        rst_n = 0; start = 1; run_time = 8'd2; cycles = 8'd2;
        step();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('0);
            if (i < 2) step();
        end
        rst_n = 1; start = 0;
        step();
        exp_q.push_back('0);
        // Stop alone and stop with start in IDLE: both must leave the block idle.
        stop = 1;
        step();
        exp_q.push_back('0);
        start = 1;
        step();
        exp_q.push_back('0);
        start = 0; stop = 0;
        step();
        exp_q.push_back('0);
        step();

        run_case(2, 1, 2, 3, 52, -1, -1, -1);
        run_case(1, 0, 1, 2, 13, -1, -1, -1);
        run_case(2, 1, 2, 3, 20, 16, -1, -1);
        run_case(2, 1, 0, 1, 3, -1, -1, -1);
        run_case(0, 1, 2, 1, 3, -1, -1, -1);
        run_case(2, 1, 2, 3, 30, -1, 10, 5);
        run_case(2, 1, 2, 3, 52, -1, -1, -1);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL queue_drain got %0d left exp 0", exp_q.size());
        end
        drv_done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        if (!drv_done) begin
            $display("FAIL timeout got running exp finished");
            $fatal(1, "timeout");
        end
    end

endmodule
